regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Shares the register file's single write port among `NREQ` writeback requesters, such as the ALU, load unit and multiplier. Each cycle it picks one valid request and registers its address and data into an output stage. That stage drives the write-enable, the 5-bit write address feeding the 5:32 write decoder, and the write data. Writes to X31 (the zero register) are accepted and then discarded. The block sits between the execute/memory writeback paths and the register file.

## Interface
- `NREQ`, 3: number of requesters, 2..8
- `DW`, 64: write data width
- `AW`, 5: register address width, fixed at 5
- `clk`  in  1: sole clock, rising edge
- `reset_n`  in  1: synchronous, active-low reset, sampled on `clk` rising edge
- `req_valid`  in  NREQ: per-requester write request
- `req_addr`  in  NREQ*AW: packed destination register, requester i at `[i*AW +: AW]`
- `req_data`  in  NREQ*DW: packed write data, same packing
- `req_ready`  out  NREQ: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`
- `rf_stall`  in  1: register file cannot accept a write this cycle
- `wr_en`  out  1: drives the enable of the 5:32 write decoder
- `wr_addr`  out  AW: register address to write
- `wr_data`  out  DW: data to write
- `wr_pending`  out  32: one-hot of `wr_addr` while `wr_en`=1, else 0 (used for hazard checks)

## Operation
- **Grant:**
  - `req_ready` is combinational from `req_valid`, the priority pointer and the stall state. At most one bit is set.
  - `req_ready` is all-zero while `rf_stall`=1 and the output stage holds a write.
  - `req_ready` is all-zero when no request is valid.
- **Accept:** on a transfer, the output stage loads the requester's address and data.
  - `wr_en` is set to 1 unless the address is 31.
  - For address 31, `wr_en` stays 0, which suppresses the write to the zero register.
- **Drain:** on a cycle with `rf_stall`=0 and no new transfer, `wr_en` falls to 0.
- **Stall:** with `rf_stall`=1, a valid output stage (`wr_en`=1) holds `wr_addr` and `wr_data` unchanged. If the output stage is empty, it may still accept a transfer.
- **Priority pointer:**
  - Points to the highest-priority requester.
  - After a grant to i, it moves to (i+1) mod NREQ.
  - It does not change on cycles with no grant.
- **Requester protocol:** a requester holds `req_valid`, `req_addr` and `req_data` stable until it sees `req_ready`. The block does not check this.
- **Same register from two requesters in the same cycle:** served in arbitration order, so the later-granted write overwrites the earlier one. Ordering between units is the requesters' responsibility.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_pending`=0, priority pointer=0.
  - During reset, `req_ready` is forced to 0.
- Latency: a transfer on cycle N makes the write visible on `wr_*` during cycle N+1.
  - The register file commits it on the rising edge that ends cycle N+1, provided `rf_stall`=0.
- Throughput: one write per cycle while `rf_stall`=0.
- `rf_stall` rising while a write is held: the write is held, and it is committed in the first cycle with `rf_stall`=0.
- Reset asserted mid-operation: any held write is dropped. No `wr_en` pulse appears in the cycle after the reset edge.
- `wr_pending` is registered together with `wr_addr`, so the two stay aligned.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: rotating priority as described under Operation.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority, lowest index wins. The pointer register is omitted and every other behaviour is identical.

## Structure
- Package `regfile_pkg`:
  - `REG_ZERO`=5'd31
  - `AW`=5
  - `NUM_REGS`=32
  - type `reg_addr_t`=logic[4:0]
- Sub-module `rr_arbiter`, parameterised by `NREQ`:
  - inputs: the request vector and an advance strobe
  - output: a one-hot grant
  - contains the priority pointer and the `ARB_ROUND_ROBIN_EN` selection
- The top module holds the output stage, the X31 suppression, the stall logic and the `wr_pending` decode.

## Test plan
- Reset and idle: hold `reset_n`=0 for 2 cycles, then release with no requests → `wr_en`=0, `wr_pending`=0 and `req_ready`=0 on every cycle.
- Single write: req0 with addr 5 and data 0xAB on cycle N → `req_ready`=001 on N; on N+1 `wr_en`=1, `wr_addr`=5, `wr_data`=0xAB and `wr_pending`=32'h20. On N+2 `wr_en`=0.
- Round-robin fairness: all three requesters valid for 6 cycles → grant order 0,1,2,0,1,2. Without the macro, the grant is requester 0 on every cycle.
- Zero-register drop: req1 with addr 31 and data 0xFF → `req_ready[1]`=1; on the next cycle `wr_en`=0 and `wr_pending`=0.
- Stall: accept addr 7, then hold `rf_stall`=1 for 3 cycles with req2 valid → `wr_addr`=7 and `wr_en`=1 held, and `req_ready`=0 throughout. When the stall drops, req2 is granted on that same cycle.
- Reset mid-hold: stalled write to addr 9, then `reset_n`=0 for 1 cycle → on the next cycle `wr_en`=0, `wr_addr`=0 and the pointer is back at 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the writeback path.
package regfile_pkg;

  localparam int unsigned AW       = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd31;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot request arbiter. Rotating priority when ARB_ROUND_ROBIN_EN is defined,
// otherwise fixed priority with the lowest index winning.
module rr_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt
);

  localparam logic [NREQ-1:0] One = {{(NREQ-1){1'b0}}, 1'b1};

`ifdef ARB_ROUND_ROBIN_EN
  localparam int unsigned PtrW = $clog2(NREQ);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] mask, req_hi, gnt_hi, gnt_lo;

  // Requests at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      mask[i] = (i >= 32'(ptr_q));
    end
    req_hi = req & mask;
    gnt_hi = req_hi & (~req_hi + One);
    gnt_lo = req & (~req + One);
    gnt    = (|req_hi) ? gnt_hi : gnt_lo;

    ptr_d = ptr_q;
    if (advance) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          ptr_d = (i == NREQ - 1) ? '0 : PtrW'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_fixed;

  assign gnt          = req & (~req + One);
  assign unused_fixed = ^{clk, reset_n, advance};
`endif

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter with a registered output stage and X31 write suppression.
// Define ARB_ROUND_ROBIN_EN for rotating priority; fixed lowest-index priority otherwise.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 64,
  parameter int unsigned AW   = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               rf_stall,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic [31:0]        wr_pending
);

  localparam logic [NUM_REGS-1:0] PendOne = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NREQ-1:0]     gnt;
  logic                stall_hold;
  logic                xfer;
  reg_addr_t           sel_addr;
  logic [DW-1:0]       sel_data;

  logic                wr_en_q, wr_en_d;
  reg_addr_t           wr_addr_q, wr_addr_d;
  logic [DW-1:0]       wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0] wr_pending_q, wr_pending_d;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req_valid),
    .advance(xfer),
    .gnt    (gnt)
  );

  // An empty output stage may still accept while the register file stalls.
  assign stall_hold = rf_stall & wr_en_q;
  assign req_ready  = (reset_n && !stall_hold) ? gnt : '0;
  assign xfer       = |req_ready;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_addr |= req_addr[i*AW +: AW];
        sel_data |= req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    wr_en_d      = wr_en_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_pending_d = wr_pending_q;
    if (xfer) begin
      wr_addr_d    = sel_addr;
      wr_data_d    = sel_data;
      wr_en_d      = (sel_addr != REG_ZERO);
      wr_pending_d = wr_en_d ? (PendOne << sel_addr) : '0;
    end else if (!rf_stall) begin
      wr_en_d      = 1'b0;
      wr_pending_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_pending_q <= '0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_pending_q <= wr_pending_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_pending = wr_pending_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed stimulus pushes expected writes,
// a negedge monitor pops and compares them the cycle after each transfer.
module tb_regfile_wr_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 64;
  localparam int unsigned AW   = 5;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rf_stall;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [31:0]        wr_pending;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [31:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic xfer_prev = 1'b0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .NREQ(NREQ),
    .DW  (DW),
    .AW  (AW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_stall  (rf_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_pending(wr_pending)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic en, input logic [4:0] a, input logic [63:0] d,
                      input logic [31:0] p);
    exp_t e;
    e.en   = en;
    e.addr = a;
    e.data = d;
    e.pend = p;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [63:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the cycle after a transfer, the output stage must show the expected write.
  always @(negedge clk) begin
    exp_t e;
    if (xfer_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: transfer seen with no expected write queued");
      end else begin
        e = exp_q.pop_front();
        check("sb_wr_en", 64'(wr_en), 64'(e.en));
        check("sb_wr_addr", 64'(wr_addr), 64'(e.addr));
        check("sb_wr_data", wr_data, e.data);
        check("sb_wr_pending", 64'(wr_pending), 64'(e.pend));
      end
    end
    xfer_prev <= reset_n && (|(req_valid & req_ready));
  end

  initial begin
    int          seq[6];
    logic [2:0]  g_exp;
`ifdef ARB_ROUND_ROBIN_EN
    seq = '{0, 1, 2, 0, 1, 2};
`else
    seq = '{0, 0, 0, 0, 0, 0};
`endif
    reset_n   = 1'b0;
    rf_stall  = 1'b0;
    req_valid = '1;
    req_addr  = '0;
    req_data  = '0;

    // Reset: ready forced low even with requests present
    @(negedge clk);
    check("rst_ready_c0", 64'(req_ready), 64'h0);
    next_cycle();
    @(negedge clk);
    check("rst_ready_c1", 64'(req_ready), 64'h0);
    check("rst_wr_en", 64'(wr_en), 64'h0);
    check("rst_wr_addr", 64'(wr_addr), 64'h0);
    check("rst_wr_data", wr_data, 64'h0);
    check("rst_wr_pending", 64'(wr_pending), 64'h0);
    next_cycle();
    reset_n   = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("idle_ready", 64'(req_ready), 64'h0);
      check("idle_wr_en", 64'(wr_en), 64'h0);
      check("idle_wr_pending", 64'(wr_pending), 64'h0);
      next_cycle();
    end

    // Single write
    set_req(0, 1'b1, 5'd5, 64'hAB);
    @(negedge clk);
    check("single_ready", 64'(req_ready), 64'h1);
    push(1'b1, 5'd5, 64'hAB, 32'h20);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("single_drain", 64'(wr_en), 64'h0);
    next_cycle();

    // Reset so the fairness run starts from pointer 0
    reset_n = 1'b0;
    @(negedge clk);
    next_cycle();
    reset_n = 1'b1;

    // Fairness: all three requesters valid for six cycles
    for (int k = 0; k < 3; k++) set_req(k, 1'b1, 5'(k + 1), 64'(32'h10 + k));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      g_exp = 3'b001 << seq[c];
      check($sformatf("fair_grant_%0d", c), 64'(req_ready), 64'(g_exp));
      push(1'b1, 5'(seq[c] + 1), 64'(32'h10 + seq[c]), 32'h1 << (seq[c] + 1));
      next_cycle();
    end
    req_valid = '0;
    @(negedge clk);
    next_cycle();

    // Zero-register write is accepted but suppressed
    set_req(1, 1'b1, 5'd31, 64'hFF);
    @(negedge clk);
    check("zero_ready", 64'(req_ready), 64'h2);
    push(1'b0, 5'd31, 64'hFF, 32'h0);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("zero_wr_en", 64'(wr_en), 64'h0);
    next_cycle();

    // Stall holds the write and blocks grants; release grants req2 at once
    set_req(0, 1'b1, 5'd7, 64'h77);
    @(negedge clk);
    check("stall_accept_ready", 64'(req_ready), 64'h1);
    push(1'b1, 5'd7, 64'h77, 32'h80);
    next_cycle();
    req_valid = '0;
    set_req(2, 1'b1, 5'd12, 64'hC2);
    rf_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall_ready_%0d", c), 64'(req_ready), 64'h0);
      check($sformatf("stall_wr_en_%0d", c), 64'(wr_en), 64'h1);
      check($sformatf("stall_wr_addr_%0d", c), 64'(wr_addr), 64'd7);
      check($sformatf("stall_wr_data_%0d", c), wr_data, 64'h77);
      next_cycle();
    end
    rf_stall = 1'b0;
    @(negedge clk);
    check("unstall_ready", 64'(req_ready), 64'h4);
    push(1'b1, 5'd12, 64'hC2, 32'h1000);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("unstall_drain", 64'(wr_en), 64'h0);
    next_cycle();

    // Reset while a stalled write is held
    set_req(0, 1'b1, 5'd9, 64'h99);
    @(negedge clk);
    check("hold_accept_ready", 64'(req_ready), 64'h1);
    push(1'b1, 5'd9, 64'h99, 32'h200);
    next_cycle();
    req_valid = '0;
    rf_stall  = 1'b1;
    @(negedge clk);
    check("hold_wr_en", 64'(wr_en), 64'h1);
    check("hold_wr_addr", 64'(wr_addr), 64'd9);
    next_cycle();
    reset_n = 1'b0;
    set_req(0, 1'b1, 5'd3, 64'h33);
    set_req(1, 1'b1, 5'd4, 64'h44);
    set_req(2, 1'b1, 5'd6, 64'h66);
    @(negedge clk);
    check("midrst_ready", 64'(req_ready), 64'h0);
    next_cycle();
    reset_n  = 1'b1;
    rf_stall = 1'b0;
    @(negedge clk);
    check("midrst_wr_en", 64'(wr_en), 64'h0);
    check("midrst_wr_addr", 64'(wr_addr), 64'h0);
    check("midrst_wr_data", wr_data, 64'h0);
    check("midrst_wr_pending", 64'(wr_pending), 64'h0);
    check("midrst_ptr_ready", 64'(req_ready), 64'h1);
    push(1'b1, 5'd3, 64'h33, 32'h8);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    next_cycle();

    check("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
